// File: rtl/dcache_resp_trace_ctrl_if.sv
// Bundles the DCache response scope signals and the outgoing trace packet
// port. The master side produces responses and consumes packets; the slave
// side is the capture controller.
interface dcache_resp_trace_ctrl_if #(
    parameter int TS_W = 16
);
    // DCache response scope
    logic            resp_valid;
    logic            resp_miss;
    logic [31:0]     resp_addr;
    logic            resp_has_data;
    logic [31:0]     resp_rdata;
    logic [6:0]      resp_id;
    logic [4:0]      resp_cmd;
    logic [1:0]      resp_size;

    // Trace packet port toward the funnel
    logic            pkt_valid;
    logic            pkt_ready;
    logic            pkt_type;
    logic [TS_W-1:0] pkt_ts;
    logic [31:0]     pkt_addr;
    logic [31:0]     pkt_data;
    logic [6:0]      pkt_id;
    logic [4:0]      pkt_cmd;
    logic            pkt_miss;
    logic [1:0]      pkt_size;

    modport master (
        output resp_valid, resp_miss, resp_addr, resp_has_data,
               resp_rdata, resp_id, resp_cmd, resp_size,
        output pkt_ready,
        input  pkt_valid, pkt_type, pkt_ts, pkt_addr, pkt_data,
               pkt_id, pkt_cmd, pkt_miss, pkt_size
    );

    modport slave (
        input  resp_valid, resp_miss, resp_addr, resp_has_data,
               resp_rdata, resp_id, resp_cmd, resp_size,
        input  pkt_ready,
        output pkt_valid, pkt_type, pkt_ts, pkt_addr, pkt_data,
               pkt_id, pkt_cmd, pkt_miss, pkt_size
    );
endinterface

// File: rtl/dcache_resp_trace_ctrl.sv
// Capture scheduler for hart-0 DCache response scope signals.
// Filters each response, timestamps it, buffers it in a small FIFO and
// drains it as trace packets. When the FIFO overflows, dropped events are
// counted and a single overflow marker carrying the drop count is queued
// ahead of any later event, so packet order always matches capture order.
module dcache_resp_trace_ctrl #(
    parameter int DEPTH = 4,   // FIFO entries, power of two, >= 2
    parameter int TS_W  = 16   // timestamp width
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          filt_miss_only,
    input  logic [31:0]                   filt_cmd_mask,
    dcache_resp_trace_ctrl_if.slave       bus,
    output logic [15:0]                   drop_total,
    output logic                          busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OVF  = 1'b1
    } state_t;

    typedef struct packed {
        logic            typ;
        logic [TS_W-1:0] ts;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [6:0]      id;
        logic [4:0]      cmd;
        logic            miss;
        logic [1:0]      size;
    } entry_t;

    // Free-running timestamp
    logic [TS_W-1:0]  ts_q;

    // FIFO storage and bookkeeping
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             pop;

    // Overflow tracking
    state_t           state_q;
    state_t           state_d;
    logic [15:0]      pend_q;
    logic [15:0]      pend_d;
    logic             push;
    logic             push_marker;
    logic             drop;

    logic             cap;
    entry_t           event_entry;
    entry_t           marker_entry;
    entry_t           push_entry;
    entry_t           head;

    // Full/empty come from the registered count only, so a same-cycle pop
    // never makes room for a push.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = ~empty & bus.pkt_ready;

    assign cap = en & bus.resp_valid & filt_cmd_mask[bus.resp_cmd]
               & (~filt_miss_only | bus.resp_miss);

    always_comb begin
        event_entry      = '0;
        event_entry.typ  = 1'b0;
        event_entry.ts   = ts_q;
        event_entry.addr = bus.resp_addr;
        event_entry.data = bus.resp_has_data ? bus.resp_rdata : 32'h0;
        event_entry.id   = bus.resp_id;
        event_entry.cmd  = bus.resp_cmd;
        event_entry.miss = bus.resp_miss;
        event_entry.size = bus.resp_size;
    end

    // Marker carries only its timestamp and the pending drop count.
    always_comb begin
        marker_entry      = '0;
        marker_entry.typ  = 1'b1;
        marker_entry.ts   = ts_q;
        marker_entry.addr = {16'h0, pend_q};
    end

    assign push_entry = push_marker ? marker_entry : event_entry;

    // Timestamp counter, wraps naturally at 2^TS_W
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Capture decision: push event, push marker, or drop into the pending count
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        push        = 1'b0;
        push_marker = 1'b0;
        drop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cap) begin
                    if (!full) begin
                        push = 1'b1;
                    end else begin
                        drop    = 1'b1;
                        pend_d  = 16'd1;
                        state_d = ST_OVF;
                    end
                end
            end
            ST_OVF: begin
                if (full) begin
                    if (cap) begin
                        drop   = 1'b1;
                        pend_d = (pend_q == 16'hFFFF) ? pend_q : pend_q + 16'd1;
                    end
                end else begin
                    // Marker takes the free slot; a capture arriving now
                    // cannot also be queued, so it opens a new drop run.
                    push        = 1'b1;
                    push_marker = 1'b1;
                    if (cap) begin
                        drop   = 1'b1;
                        pend_d = 16'd1;
                    end else begin
                        pend_d  = 16'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 16'd0;
            end
        endcase
    end

    // Overflow state and pending drop count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Sticky saturating drop counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_total <= 16'd0;
        end else if (drop && drop_total != 16'hFFFF) begin
            drop_total <= drop_total + 16'd1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage write
    // NOTE: the storage array has no reset; packet outputs are masked by
    // pkt_valid, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // Head entry is held until popped, which keeps outputs stable under
    // backpressure; forcing zero when empty gives all-zero outputs in reset.
    assign head = empty ? '0 : mem[rd_ptr_q];

    assign bus.pkt_valid = ~empty;
    assign bus.pkt_type  = head.typ;
    assign bus.pkt_ts    = head.ts;
    assign bus.pkt_addr  = head.addr;
    assign bus.pkt_data  = head.data;
    assign bus.pkt_id    = head.id;
    assign bus.pkt_cmd   = head.cmd;
    assign bus.pkt_miss  = head.miss;
    assign bus.pkt_size  = head.size;

    assign busy = ~empty | (state_q == ST_OVF);

endmodule

// File: tb/tb_dcache_resp_trace_ctrl.sv
// Randomized and directed bench for dcache_resp_trace_ctrl. A reference
// model tracks occupancy, overflow runs and drop counts with plain integers
// and queues the expected packets; a monitor compares every presented packet.
module tb_dcache_resp_trace_ctrl;

    localparam int DEPTH  = 4;
    localparam int TS_W   = 4;
    localparam int TS_MOD = 1 << TS_W;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en;
    logic        filt_miss_only;
    logic [31:0] filt_cmd_mask;
    logic [15:0] drop_total;
    logic        busy;

    dcache_resp_trace_ctrl_if #(.TS_W(TS_W)) bus ();

    dcache_resp_trace_ctrl #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .en             (en),
        .filt_miss_only (filt_miss_only),
        .filt_cmd_mask  (filt_cmd_mask),
        .bus            (bus),
        .drop_total     (drop_total),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            typ;
        bit [TS_W-1:0] ts;
        bit [31:0]     addr;
        bit [31:0]     data;
        bit [6:0]      id;
        bit [4:0]      cmd;
        bit            miss;
        bit [1:0]      size;
    } pkt_t;

    pkt_t sb[$];
    int   m_occ   = 0;
    int   m_pend  = 0;
    int   m_drops = 0;
    int   m_ts    = 0;
    bit   m_ovf   = 1'b0;
    int   n_pop   = 0;

    int   tests_run = 0;
    int   fails     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one capture decision per clock edge
    always @(posedge clock or posedge reset) begin : model_b
        bit   cap;
        bit   full;
        bit   pop;
        bit   push;
        pkt_t p;
        if (reset) begin
            sb.delete();
            m_occ   = 0;
            m_pend  = 0;
            m_drops = 0;
            m_ts    = 0;
            m_ovf   = 1'b0;
        end else begin
            cap  = en && bus.resp_valid && filt_cmd_mask[bus.resp_cmd]
                   && (!filt_miss_only || bus.resp_miss);
            full = (m_occ == DEPTH);
            pop  = (m_occ != 0) && bus.pkt_ready;
            push = 1'b0;
            p.typ  = 1'b0;
            p.ts   = m_ts[TS_W-1:0];
            p.addr = bus.resp_addr;
            p.data = bus.resp_has_data ? bus.resp_rdata : 32'h0;
            p.id   = bus.resp_id;
            p.cmd  = bus.resp_cmd;
            p.miss = bus.resp_miss;
            p.size = bus.resp_size;
            if (!m_ovf) begin
                if (cap && !full) begin
                    push = 1'b1;
                end else if (cap) begin
                    if (m_drops < 65535) m_drops++;
                    m_pend = 1;
                    m_ovf  = 1'b1;
                end
            end else if (full) begin
                if (cap) begin
                    if (m_drops < 65535) m_drops++;
                    if (m_pend < 65535) m_pend++;
                end
            end else begin
                p.typ  = 1'b1;
                p.addr = 32'(m_pend);
                p.data = 32'h0;
                p.id   = 7'h0;
                p.cmd  = 5'h0;
                p.miss = 1'b0;
                p.size = 2'h0;
                push   = 1'b1;
                if (cap) begin
                    if (m_drops < 65535) m_drops++;
                    m_pend = 1;
                end else begin
                    m_pend = 0;
                    m_ovf  = 1'b0;
                end
            end
            if (push) sb.push_back(p);
            m_occ = m_occ + int'(push) - int'(pop);
            m_ts  = (m_ts + 1) % TS_MOD;
        end
    end

    // Monitor: compare presented packets and status against the model
    always @(negedge clock) begin : monitor_b
        pkt_t e;
        if (!reset) begin
            check("pkt_valid", 64'(bus.pkt_valid), 64'(m_occ != 0));
            check("busy", 64'(busy), 64'((m_occ != 0) || m_ovf));
            check("drop_total", 64'(drop_total), 64'(m_drops));
            if (bus.pkt_valid) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_pkt: got addr 0x%0h, expected no packet at %0t",
                             bus.pkt_addr, $time);
                end else begin
                    e = sb[0];
                    check("pkt_hdr",
                          64'({bus.pkt_type, bus.pkt_ts, bus.pkt_id, bus.pkt_cmd,
                               bus.pkt_miss, bus.pkt_size}),
                          64'({e.typ, e.ts, e.id, e.cmd, e.miss, e.size}));
                    check("pkt_addr", 64'(bus.pkt_addr), 64'(e.addr));
                    check("pkt_data", 64'(bus.pkt_data), 64'(e.data));
                    if (bus.pkt_ready) begin
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        bus.resp_valid    = 1'b0;
        bus.resp_miss     = 1'b0;
        bus.resp_addr     = 32'h0;
        bus.resp_has_data = 1'b0;
        bus.resp_rdata    = 32'h0;
        bus.resp_id       = 7'h0;
        bus.resp_cmd      = 5'h0;
        bus.resp_size     = 2'h0;
    endtask

    task automatic send(input logic [4:0] cmd, input logic miss, input logic [31:0] addr,
                        input logic hd, input logic [31:0] rd);
        bus.resp_valid    = 1'b1;
        bus.resp_cmd      = cmd;
        bus.resp_miss     = miss;
        bus.resp_addr     = addr;
        bus.resp_has_data = hd;
        bus.resp_rdata    = rd;
        bus.resp_id       = 7'($urandom);
        bus.resp_size     = 2'($urandom);
        step();
    endtask

    task automatic drain();
        int n;
        idle();
        bus.pkt_ready = 1'b1;
        n = 0;
        while ((m_occ != 0 || m_ovf || sb.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check("drain_done", 64'(m_occ == 0 && !m_ovf && sb.size() == 0), 64'(1));
    endtask

    task automatic do_reset(input bit check_zero);
        #1 reset = 1'b1;
        #1;
        if (check_zero) begin
            check("rst_pkt_valid", 64'(bus.pkt_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_drop_total", 64'(drop_total), 64'(0));
            check("rst_pkt_addr", 64'(bus.pkt_addr), 64'(0));
        end
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin : watchdog_b
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim_b
        int base;
        int n;
        logic [31:0] snap_addr;
        logic [31:0] snap_data;
        logic [15:0] snap_hdr;

        en             = 1'b0;
        filt_miss_only = 1'b0;
        filt_cmd_mask  = 32'h0;
        bus.pkt_ready  = 1'b1;
        idle();
        do_reset(1'b1);

        // Command filter: only the load (cmd 0) is captured
        en            = 1'b1;
        filt_cmd_mask = 32'h1;
        base = n_pop;
        send(5'd0, 1'b0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF);
        send(5'd1, 1'b0, 32'h8000_0020, 1'b1, 32'h1111_2222);
        drain();
        check("filter_count", 64'(n_pop - base), 64'(1));

        // Miss-only filter and data zeroing
        filt_miss_only = 1'b1;
        base = n_pop;
        send(5'd0, 1'b0, 32'h0000_0100, 1'b1, 32'hAAAA_5555);
        send(5'd0, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_1234);
        drain();
        check("miss_count", 64'(n_pop - base), 64'(1));

        // Overflow: 7 captures into a 4-entry FIFO with the sink stalled
        do_reset(1'b0);
        en             = 1'b1;
        filt_miss_only = 1'b0;
        filt_cmd_mask  = 32'hFFFF_FFFF;
        bus.pkt_ready  = 1'b0;
        for (int i = 0; i < 7; i++) send(5'(i), 1'(i), 32'h1000 + 32'(i), 1'b1, 32'(i));
        idle();
        step();
        base = n_pop;
        drain();
        check("ovf_pkt_count", 64'(n_pop - base), 64'(5));
        check("ovf_drop_total", 64'(drop_total), 64'(3));
        check("ovf_idle_busy", 64'(busy), 64'(0));

        // Marker-cycle collision: capture while the marker takes the freed slot
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(5'd2, 1'b1, 32'h2000 + 32'(i), 1'b0, 32'h0);
        bus.pkt_ready = 1'b1;
        send(5'd3, 1'b0, 32'h2100, 1'b1, 32'h55);
        send(5'd3, 1'b0, 32'h2104, 1'b1, 32'h66);
        bus.pkt_ready = 1'b0;
        idle();
        step();
        check("collide_busy", 64'(busy), 64'(1));
        drain();

        // Backpressure hold and timestamp wrap (15 then 0)
        bus.pkt_ready = 1'b0;
        n = 0;
        while (m_ts != TS_MOD - 1 && n < 40) begin
            step();
            n++;
        end
        send(5'd4, 1'b1, 32'h3000_000F, 1'b1, 32'hF00D_0001);
        send(5'd5, 1'b0, 32'h3000_0000, 1'b1, 32'hF00D_0002);
        idle();
        step();
        snap_addr = bus.pkt_addr;
        snap_data = bus.pkt_data;
        snap_hdr  = {bus.pkt_type, bus.pkt_ts, bus.pkt_id, bus.pkt_cmd[3:0]};
        repeat (3) step();
        check("hold_addr", 64'(bus.pkt_addr), 64'(snap_addr));
        check("hold_data", 64'(bus.pkt_data), 64'(snap_data));
        check("hold_hdr", 64'({bus.pkt_type, bus.pkt_ts, bus.pkt_id, bus.pkt_cmd[3:0]}),
              64'(snap_hdr));
        check("wrap_first_ts", 64'(bus.pkt_ts), 64'(TS_MOD - 1));
        drain();

        // Reset in the middle of an overflow run with a loaded FIFO
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(5'd6, 1'b0, 32'h4000 + 32'(i), 1'b1, 32'(i));
        idle();
        do_reset(1'b1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                filt_cmd_mask  = $urandom() | 32'h1;
                filt_miss_only = ($urandom_range(0, 3) == 0);
            end
            en                = ($urandom_range(0, 9) != 0);
            bus.pkt_ready     = ($urandom_range(0, 1) == 1);
            bus.resp_valid    = ($urandom_range(0, 9) < 6);
            bus.resp_cmd      = 5'($urandom_range(0, 7));
            bus.resp_miss     = 1'($urandom);
            bus.resp_addr     = $urandom();
            bus.resp_has_data = 1'($urandom);
            bus.resp_rdata    = $urandom();
            bus.resp_id       = 7'($urandom);
            bus.resp_size     = 2'($urandom);
            step();
        end
        en = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
